// File: rtl/mem_stage.sv
// AsyncARM memory-access stage: sits between the ALU and writeback, passes non-memory ops through
// and turns loads/stores into sized, byte-enabled RAM requests with alignment faults and optional posted stores.
module mem_stage #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter bit STORE_WAIT = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_m,
   input  logic [DW-1:0]   in_data1,
   input  logic [DW-1:0]   in_data2,
   input  logic [DW-1:0]   in_srcdst,
   input  logic [31:0]     in_cpsr,
   input  logic            in_w,
   input  logic [1:0]      in_size,
   input  logic            in_signed,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [DW-1:0]   wb_data1,
   output logic [DW-1:0]   wb_data2,
   output logic [DW-1:0]   wb_srcdst,
   output logic [31:0]     wb_cpsr,
   output logic            wb_w,
   output logic            wb_fault,
   output logic            ram_req,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_wdata,
   output logic [DW/8-1:0] ram_be,
   input  logic            ram_ack,
   input  logic [DW-1:0]   ram_rdata
);

   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [2:0] {IDLE, RD, WR, OUT, PST} state_t;

   state_t          state_reg, state_next;
   logic [DW-1:0]   data1_reg, data1_next;
   logic [DW-1:0]   data2_reg, data2_next;
   logic [DW-1:0]   srcdst_reg, srcdst_next;
   logic [31:0]     cpsr_reg, cpsr_next;
   logic            w_reg, w_next;
   logic            fault_reg, fault_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic            we_reg, we_next;
   logic [NB-1:0]   be_reg, be_next;
   logic [DW-1:0]   wdata_reg, wdata_next;
   logic [1:0]      size_reg, size_next;
   logic            sgn_reg, sgn_next;
   logic [LB-1:0]   lane_reg, lane_next;
   logic            ack_seen_reg, ack_seen_next;
   logic            wb_seen_reg, wb_seen_next;

   // Decode of the operation currently offered on the input side
   logic            op_load;
   logic [AW-1:0]   op_addr;
   logic [3:0]      op_nbytes;
   logic [2:0]      op_align_mask;
   logic [LB-1:0]   op_lane_mask;
   logic [LB-1:0]   op_lane;
   logic            op_fault;
   logic [NB-1:0]   op_be;
   logic [DW-1:0]   op_wdata;
   logic [7:0]      in_bytes [NB];

   // Load-return path: align selected lanes to bit 0, then extend
   logic [DW-1:0]   rd_shift;
   logic [3:0]      rd_nbytes;
   logic [LB-1:0]   rd_msb;
   logic [NB-1:0]   rd_sign_bits;
   logic            rd_sign;
   logic [DW-1:0]   rd_ext;

   assign op_load       = in_m && (in_data1 != '0);
   assign op_addr       = op_load ? in_data2[AW-1:0] : in_srcdst[AW-1:0];
   assign op_nbytes     = 4'd1 << in_size;
   assign op_align_mask = 3'(op_nbytes - 4'd1);
   assign op_lane_mask  = LB'(op_nbytes - 4'd1);
   assign op_lane       = op_addr[LB-1:0];
   assign op_fault      = in_m && ((in_size > 2'(LB)) || ((op_addr[2:0] & op_align_mask) != 3'd0));

   assign rd_shift  = ram_rdata >> {lane_reg, 3'b000};
   assign rd_nbytes = 4'd1 << size_reg;
   assign rd_msb    = LB'(rd_nbytes - 4'd1);
   assign rd_sign   = sgn_reg & rd_sign_bits[rd_msb];

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         localparam logic [4:0] GI = 5'(gi);
         logic [LB-1:0] src_lane;

         assign in_bytes[gi]      = in_data2[8*gi +: 8];
         assign op_be[gi]         = (GI >= 5'(op_lane)) && (GI < 5'(op_lane) + 5'(op_nbytes));
         // Small stores are replicated so every lane carries the datum; byte enables pick the live one
         assign src_lane          = LB'(gi) & op_lane_mask;
         assign op_wdata[8*gi +: 8] = in_bytes[src_lane];
         assign rd_sign_bits[gi]  = rd_shift[8*gi + 7];
         assign rd_ext[8*gi +: 8] = (GI < 5'(rd_nbytes)) ? rd_shift[8*gi +: 8] : {8{rd_sign}};
      end
   endgenerate

   assign in_ready  = reset && ((state_reg == IDLE) || ((state_reg == OUT) && wb_ready));
   assign wb_valid  = (state_reg == OUT) || ((state_reg == PST) && !wb_seen_reg);
   assign ram_req   = (state_reg == RD) || (state_reg == WR) || ((state_reg == PST) && !ack_seen_reg);
   assign wb_data1  = data1_reg;
   assign wb_data2  = data2_reg;
   assign wb_srcdst = srcdst_reg;
   assign wb_cpsr   = cpsr_reg;
   assign wb_w      = w_reg;
   assign wb_fault  = fault_reg;
   assign ram_we    = we_reg;
   assign ram_addr  = addr_reg;
   assign ram_be    = be_reg;
   assign ram_wdata = wdata_reg;

   always_comb begin
      state_next    = state_reg;
      data1_next    = data1_reg;
      data2_next    = data2_reg;
      srcdst_next   = srcdst_reg;
      cpsr_next     = cpsr_reg;
      w_next        = w_reg;
      fault_next    = fault_reg;
      addr_next     = addr_reg;
      we_next       = we_reg;
      be_next       = be_reg;
      wdata_next    = wdata_reg;
      size_next     = size_reg;
      sgn_next      = sgn_reg;
      lane_next     = lane_reg;
      ack_seen_next = ack_seen_reg;
      wb_seen_next  = wb_seen_reg;

      case (state_reg)
         RD: begin
            if (ram_ack) begin
               data1_next = rd_ext;
               state_next = OUT;
            end
         end
         WR: begin
            if (ram_ack) state_next = OUT;
         end
         OUT: begin
            if (wb_ready) state_next = IDLE;
         end
         PST: begin
            // Either event may come first; leave once both have been observed
            if ((ack_seen_reg || ram_ack) && (wb_seen_reg || wb_ready)) begin
               state_next = IDLE;
            end else begin
               ack_seen_next = ack_seen_reg | ram_ack;
               wb_seen_next  = wb_seen_reg | wb_ready;
            end
         end
         default: ;
      endcase

      if (in_valid && in_ready) begin
         data2_next    = in_data2;
         srcdst_next   = in_srcdst;
         cpsr_next     = in_cpsr;
         w_next        = in_w & ~op_fault;
         fault_next    = op_fault;
         data1_next    = in_m ? '0 : in_data1;
         size_next     = in_size;
         sgn_next      = in_signed;
         lane_next     = op_lane;
         ack_seen_next = 1'b0;
         wb_seen_next  = 1'b0;
         if (!in_m || op_fault) begin
            state_next = OUT;
         end else begin
            addr_next  = op_addr;
            we_next    = !op_load;
            be_next    = op_be;
            wdata_next = op_wdata;
            if (op_load)         state_next = RD;
            else if (STORE_WAIT) state_next = WR;
            else                 state_next = PST;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         data1_reg    <= '0;
         data2_reg    <= '0;
         srcdst_reg   <= '0;
         cpsr_reg     <= '0;
         w_reg        <= 1'b0;
         fault_reg    <= 1'b0;
         addr_reg     <= '0;
         we_reg       <= 1'b0;
         be_reg       <= '0;
         wdata_reg    <= '0;
         size_reg     <= '0;
         sgn_reg      <= 1'b0;
         lane_reg     <= '0;
         ack_seen_reg <= 1'b0;
         wb_seen_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         data1_reg    <= data1_next;
         data2_reg    <= data2_next;
         srcdst_reg   <= srcdst_next;
         cpsr_reg     <= cpsr_next;
         w_reg        <= w_next;
         fault_reg    <= fault_next;
         addr_reg     <= addr_next;
         we_reg       <= we_next;
         be_reg       <= be_next;
         wdata_reg    <= wdata_next;
         size_reg     <= size_next;
         sgn_reg      <= sgn_next;
         lane_reg     <= lane_next;
         ack_seen_reg <= ack_seen_next;
         wb_seen_reg  <= wb_seen_next;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one waited-store instance and one posted-store instance,
// writeback results checked against a queue of expected results.
module tb_mem_stage;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_in_m, a_in_w, a_in_signed;
   logic [31:0] a_in_data1, a_in_data2, a_in_srcdst, a_in_cpsr;
   logic [1:0]  a_in_size;
   logic        a_wb_valid, a_wb_ready, a_wb_w, a_wb_fault;
   logic [31:0] a_wb_data1, a_wb_data2, a_wb_srcdst, a_wb_cpsr;
   logic        a_ram_req, a_ram_we, a_ram_ack;
   logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
   logic [3:0]  a_ram_be;

   logic        p_in_valid, p_in_ready, p_in_m, p_in_w, p_in_signed;
   logic [31:0] p_in_data1, p_in_data2, p_in_srcdst, p_in_cpsr;
   logic [1:0]  p_in_size;
   logic        p_wb_valid, p_wb_ready, p_wb_w, p_wb_fault;
   logic [31:0] p_wb_data1, p_wb_data2, p_wb_srcdst, p_wb_cpsr;
   logic        p_ram_req, p_ram_we, p_ram_ack;
   logic [31:0] p_ram_addr, p_ram_wdata, p_ram_rdata;
   logic [3:0]  p_ram_be;

   mem_stage #(.DW(32), .AW(32), .STORE_WAIT(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_m(a_in_m),
      .in_data1(a_in_data1), .in_data2(a_in_data2), .in_srcdst(a_in_srcdst),
      .in_cpsr(a_in_cpsr), .in_w(a_in_w), .in_size(a_in_size), .in_signed(a_in_signed),
      .wb_valid(a_wb_valid), .wb_ready(a_wb_ready), .wb_data1(a_wb_data1),
      .wb_data2(a_wb_data2), .wb_srcdst(a_wb_srcdst), .wb_cpsr(a_wb_cpsr),
      .wb_w(a_wb_w), .wb_fault(a_wb_fault),
      .ram_req(a_ram_req), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
      .ram_wdata(a_ram_wdata), .ram_be(a_ram_be), .ram_ack(a_ram_ack), .ram_rdata(a_ram_rdata)
   );

   mem_stage #(.DW(32), .AW(32), .STORE_WAIT(1'b0)) u_pst (
      .clk(clk), .reset(reset),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_m(p_in_m),
      .in_data1(p_in_data1), .in_data2(p_in_data2), .in_srcdst(p_in_srcdst),
      .in_cpsr(p_in_cpsr), .in_w(p_in_w), .in_size(p_in_size), .in_signed(p_in_signed),
      .wb_valid(p_wb_valid), .wb_ready(p_wb_ready), .wb_data1(p_wb_data1),
      .wb_data2(p_wb_data2), .wb_srcdst(p_wb_srcdst), .wb_cpsr(p_wb_cpsr),
      .wb_w(p_wb_w), .wb_fault(p_wb_fault),
      .ram_req(p_ram_req), .ram_we(p_ram_we), .ram_addr(p_ram_addr),
      .ram_wdata(p_ram_wdata), .ram_be(p_ram_be), .ram_ack(p_ram_ack), .ram_rdata(p_ram_rdata)
   );

   typedef struct {
      logic [31:0] data1;
      logic [31:0] srcdst;
      logic [31:0] cpsr;
      logic        w;
      logic        fault;
   } exp_t;

   exp_t a_q[$];
   exp_t p_q[$];
   exp_t a_e, p_e;
   int   checks = 0;
   int   errors = 0;
   bit   a_forbid_req = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input bit to_p, input logic [31:0] d1, sd, cp, input logic w, f);
      exp_t e;
      e.data1 = d1; e.srcdst = sd; e.cpsr = cp; e.w = w; e.fault = f;
      if (to_p) p_q.push_back(e);
      else      a_q.push_back(e);
   endtask

   task automatic a_drive(input logic m, input logic [31:0] d1, d2, sd, cp,
                          input logic [1:0] sz, input logic sg, input logic w);
      a_in_valid = 1'b1; a_in_m = m; a_in_data1 = d1; a_in_data2 = d2;
      a_in_srcdst = sd; a_in_cpsr = cp; a_in_size = sz; a_in_signed = sg; a_in_w = w;
   endtask

   task automatic p_drive(input logic [31:0] d2, sd, cp, input logic [1:0] sz);
      p_in_valid = 1'b1; p_in_m = 1'b1; p_in_data1 = 32'h0; p_in_data2 = d2;
      p_in_srcdst = sd; p_in_cpsr = cp; p_in_size = sz; p_in_signed = 1'b0; p_in_w = 1'b1;
   endtask

   // Load with the RAM acknowledging on the third edge after acceptance
   task automatic a_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] rdata, input logic [3:0] be_exp,
                         input logic [31:0] d_exp);
      a_drive(1'b1, 32'h1, addr, 32'h5, 32'h6000_0000, sz, sg, 1'b1);
      push_exp(1'b0, d_exp, 32'h5, 32'h6000_0000, 1'b1, 1'b0);
      step();
      a_in_valid = 1'b0;
      check({tag, "_req"}, a_ram_req, 1);
      check({tag, "_we"}, a_ram_we, 0);
      check({tag, "_addr"}, a_ram_addr, addr);
      check({tag, "_be"}, a_ram_be, be_exp);
      check({tag, "_wait_valid"}, a_wb_valid, 0);
      step();
      check({tag, "_req_held"}, a_ram_req, 1);
      step();
      check({tag, "_addr_held"}, a_ram_addr, addr);
      a_ram_ack = 1'b1; a_ram_rdata = rdata;
      step();
      a_ram_ack = 1'b0; a_ram_rdata = 32'h0;
      check({tag, "_req_drop"}, a_ram_req, 0);
      check({tag, "_valid"}, a_wb_valid, 1);
      check({tag, "_data"}, a_wb_data1, d_exp);
      step();
      check({tag, "_valid_done"}, a_wb_valid, 0);
   endtask

   always @(negedge clk) begin
      if (a_wb_valid && a_wb_ready) begin
         if (a_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL a_unexpected_wb: observed data1 %0h expected no result", a_wb_data1);
         end else begin
            a_e = a_q.pop_front();
            $display("a wb: data1=%h srcdst=%h w=%b fault=%b", a_wb_data1, a_wb_srcdst, a_wb_w, a_wb_fault);
            check("a_wb_data1", a_wb_data1, a_e.data1);
            check("a_wb_srcdst", a_wb_srcdst, a_e.srcdst);
            check("a_wb_cpsr", a_wb_cpsr, a_e.cpsr);
            check("a_wb_w", a_wb_w, a_e.w);
            check("a_wb_fault", a_wb_fault, a_e.fault);
         end
      end
      if (a_forbid_req) check("a_no_ram_req", a_ram_req, 0);
   end

   always @(negedge clk) begin
      if (p_wb_valid && p_wb_ready) begin
         if (p_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL p_unexpected_wb: observed data1 %0h expected no result", p_wb_data1);
         end else begin
            p_e = p_q.pop_front();
            $display("p wb: data1=%h srcdst=%h w=%b fault=%b", p_wb_data1, p_wb_srcdst, p_wb_w, p_wb_fault);
            check("p_wb_data1", p_wb_data1, p_e.data1);
            check("p_wb_srcdst", p_wb_srcdst, p_e.srcdst);
            check("p_wb_cpsr", p_wb_cpsr, p_e.cpsr);
            check("p_wb_w", p_wb_w, p_e.w);
            check("p_wb_fault", p_wb_fault, p_e.fault);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      a_in_valid = 0; a_in_m = 0; a_in_w = 0; a_in_signed = 0; a_in_size = 0;
      a_in_data1 = 0; a_in_data2 = 0; a_in_srcdst = 0; a_in_cpsr = 0;
      a_wb_ready = 1'b1; a_ram_ack = 0; a_ram_rdata = 0;
      p_in_valid = 0; p_in_m = 0; p_in_w = 0; p_in_signed = 0; p_in_size = 0;
      p_in_data1 = 0; p_in_data2 = 0; p_in_srcdst = 0; p_in_cpsr = 0;
      p_wb_ready = 1'b0; p_ram_ack = 0; p_ram_rdata = 0;

      // Reset state
      repeat (3) step();
      check("rst_a_in_ready", a_in_ready, 0);
      check("rst_a_wb_valid", a_wb_valid, 0);
      check("rst_a_ram_req", a_ram_req, 0);
      check("rst_a_wb_data1", a_wb_data1, 0);
      check("rst_a_ram_be", a_ram_be, 0);
      check("rst_p_in_ready", p_in_ready, 0);
      check("rst_p_wb_valid", p_wb_valid, 0);
      reset = 1'b1;
      step();
      check("a_ready_after_reset", a_in_ready, 1);
      check("p_ready_after_reset", p_in_ready, 1);

      // Single non-memory op, then a back-to-back stream of four
      a_forbid_req = 1'b1;
      a_drive(1'b0, 32'h1234, 32'hAAAA, 32'h7, 32'h8000_0000, 2'd0, 1'b0, 1'b1);
      push_exp(1'b0, 32'h1234, 32'h7, 32'h8000_0000, 1'b1, 1'b0);
      step();
      a_in_valid = 1'b0;
      check("nm_valid", a_wb_valid, 1);
      check("nm_data1", a_wb_data1, 32'h1234);
      check("nm_w", a_wb_w, 1);
      step();
      check("nm_valid_done", a_wb_valid, 0);
      for (int k = 0; k < 4; k++) begin
         a_drive(1'b0, 32'h100 + k, 32'h0, 32'h10 + k, 32'h1000_0000 * k, 2'd0, 1'b0, k[0]);
         push_exp(1'b0, 32'h100 + k, 32'h10 + k, 32'h1000_0000 * k, k[0], 1'b0);
         step();
         check("b2b_valid", a_wb_valid, 1);
         check("b2b_ready", a_in_ready, 1);
         check("b2b_data1", a_wb_data1, 32'h100 + k);
      end
      a_in_valid = 1'b0;
      step();
      check("b2b_drained", a_wb_valid, 0);
      a_forbid_req = 1'b0;

      // Loads of several sizes and signedness
      a_load("ldsb", 32'h103, 2'd0, 1'b1, 32'h80FF_EE11, 4'b1000, 32'hFFFF_FF80);
      a_load("ldub", 32'h103, 2'd0, 1'b0, 32'h80FF_EE11, 4'b1000, 32'h0000_0080);
      a_load("ldsh", 32'h102, 2'd1, 1'b1, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
      a_load("ldw",  32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      // Halfword store waiting for the acknowledge
      a_drive(1'b1, 32'h0, 32'hCAFE_BABE, 32'h202, 32'h2000_0000, 2'd1, 1'b0, 1'b1);
      push_exp(1'b0, 32'h0, 32'h202, 32'h2000_0000, 1'b1, 1'b0);
      step();
      a_in_valid = 1'b0;
      check("sth_req", a_ram_req, 1);
      check("sth_we", a_ram_we, 1);
      check("sth_addr", a_ram_addr, 32'h202);
      check("sth_be", a_ram_be, 4'b1100);
      check("sth_wdata", a_ram_wdata, 32'hBABE_BABE);
      check("sth_wait_valid", a_wb_valid, 0);
      step();
      check("sth_wait_valid2", a_wb_valid, 0);
      a_ram_ack = 1'b1;
      step();
      a_ram_ack = 1'b0;
      check("sth_req_drop", a_ram_req, 0);
      check("sth_valid", a_wb_valid, 1);
      step();

      // Alignment and size faults make no RAM access
      a_forbid_req = 1'b1;
      a_drive(1'b1, 32'h1, 32'h101, 32'h9, 32'h3000_0000, 2'd2, 1'b0, 1'b1);
      push_exp(1'b0, 32'h0, 32'h9, 32'h3000_0000, 1'b0, 1'b1);
      step();
      check("mis_valid", a_wb_valid, 1);
      check("mis_fault", a_wb_fault, 1);
      a_drive(1'b1, 32'h1, 32'h100, 32'hA, 32'h3000_0001, 2'd3, 1'b0, 1'b1);
      push_exp(1'b0, 32'h0, 32'hA, 32'h3000_0001, 1'b0, 1'b1);
      step();
      a_in_valid = 1'b0;
      check("dw_fault", a_wb_fault, 1);
      step();
      a_forbid_req = 1'b0;

      // Posted store: ack first, writeback later
      p_drive(32'h1122_3344, 32'h300, 32'h4000_0000, 2'd2);
      push_exp(1'b1, 32'h0, 32'h300, 32'h4000_0000, 1'b1, 1'b0);
      step();
      p_in_valid = 1'b0;
      check("pst_req", p_ram_req, 1);
      check("pst_valid", p_wb_valid, 1);
      check("pst_ready0", p_in_ready, 0);
      check("pst_we", p_ram_we, 1);
      check("pst_wdata", p_ram_wdata, 32'h1122_3344);
      check("pst_be", p_ram_be, 4'b1111);
      step();
      check("pst_req_held", p_ram_req, 1);
      p_ram_ack = 1'b1;
      step();
      p_ram_ack = 1'b0;
      check("pst_req_drop", p_ram_req, 0);
      check("pst_valid_held", p_wb_valid, 1);
      check("pst_ready_after_ack", p_in_ready, 0);
      step();
      check("pst_ready_still0", p_in_ready, 0);
      p_wb_ready = 1'b1;
      step();
      check("pst_ready_both", p_in_ready, 1);
      check("pst_valid_done", p_wb_valid, 0);
      p_wb_ready = 1'b0;

      // Posted store: ack and writeback in the same cycle
      p_drive(32'h0000_0055, 32'h301, 32'h4000_0001, 2'd0);
      push_exp(1'b1, 32'h0, 32'h301, 32'h4000_0001, 1'b1, 1'b0);
      step();
      p_in_valid = 1'b0;
      check("pst2_be", p_ram_be, 4'b0010);
      check("pst2_wdata", p_ram_wdata, 32'h5555_5555);
      check("pst2_ready0", p_in_ready, 0);
      p_ram_ack = 1'b1;
      p_wb_ready = 1'b1;
      step();
      p_ram_ack = 1'b0;
      p_wb_ready = 1'b0;
      check("pst2_ready", p_in_ready, 1);
      check("pst2_req", p_ram_req, 0);
      check("pst2_valid", p_wb_valid, 0);

      // Reset while a load waits; a late ack must be ignored
      a_drive(1'b1, 32'h1, 32'h400, 32'hB, 32'h5000_0000, 2'd2, 1'b0, 1'b1);
      step();
      a_in_valid = 1'b0;
      check("rrd_req", a_ram_req, 1);
      reset = 1'b0;
      step();
      check("rrd_req_drop", a_ram_req, 0);
      check("rrd_valid", a_wb_valid, 0);
      check("rrd_ready", a_in_ready, 0);
      check("rrd_be", a_ram_be, 0);
      check("rrd_addr", a_ram_addr, 0);
      check("rrd_data2", a_wb_data2, 0);
      reset = 1'b1;
      a_ram_ack = 1'b1;
      a_ram_rdata = 32'h0000_FFFF;
      step();
      a_ram_ack = 1'b0;
      check("late_ack_valid", a_wb_valid, 0);
      step();
      check("late_ack_valid2", a_wb_valid, 0);
      check("late_ack_ready", a_in_ready, 1);

      check("a_queue_empty", a_q.size(), 0);
      check("p_queue_empty", p_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
